// File: rtl/hbridge_pkg.sv
// Shared types and constants for the H-bridge coil model.
package hbridge_pkg;

  localparam int unsigned CUR_W        = 13;
  localparam int unsigned ARITH_W      = CUR_W + 1;
  localparam int unsigned IMAX_DEFAULT = 4095;

  typedef enum logic [2:0] {
    BR_OFF   = 3'd0,
    BR_FWD   = 3'd1,
    BR_REV   = 3'd2,
    BR_SLOW  = 3'd3,
    BR_SHOOT = 3'd4
  } bridge_state_e;

  // Step a value toward zero by step, stopping at zero rather than crossing it.
  function automatic logic signed [ARITH_W-1:0] decay_toward_zero(
    input logic signed [ARITH_W-1:0] val,
    input logic signed [ARITH_W-1:0] step
  );
    logic signed [ARITH_W-1:0] res;
    res = val;
    if (val > 0) begin
      res = val - step;
      if (res < 0) res = '0;
    end else if (val < 0) begin
      res = val + step;
      if (res > 0) res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/hbridge_coil_model_if.sv
// Gate drive and coil feedback bundle between a motor controller and the coil model.
interface hbridge_coil_model_if;
  import hbridge_pkg::*;

  logic                    high_1;
  logic                    low_1;
  logic                    high_2;
  logic                    low_2;
  logic                    polarity_invert_config;
  logic signed [CUR_W-1:0] current;
  logic                    fault;
  logic [2:0]              bridge_state;

  modport master (
    output high_1, low_1, high_2, low_2, polarity_invert_config,
    input  current, fault, bridge_state
  );

  modport slave (
    input  high_1, low_1, high_2, low_2, polarity_invert_config,
    output current, fault, bridge_state
  );
endinterface

// File: rtl/hbridge_decode.sv
// Polarity swap followed by priority decode of the four bridge gates.
module hbridge_decode
  import hbridge_pkg::*;
(
  input  logic          high_1,
  input  logic          low_1,
  input  logic          high_2,
  input  logic          low_2,
  input  logic          polarity_invert,
  output bridge_state_e state_c
);

  logic h1;
  logic l1;
  logic h2;
  logic l2;

  // Swap sides when polarity is inverted, then decode with shoot-through first.
  always_comb begin
    h1      = polarity_invert ? high_2 : high_1;
    l1      = polarity_invert ? low_2  : low_1;
    h2      = polarity_invert ? high_1 : high_2;
    l2      = polarity_invert ? low_1  : low_2;
    state_c = BR_OFF;
    if ((h1 && l1) || (h2 && l2)) begin
      state_c = BR_SHOOT;
    end else if (h1 && l2 && !l1 && !h2) begin
      state_c = BR_FWD;
    end else if (h2 && l1 && !h1 && !l2) begin
      state_c = BR_REV;
    end else if ((l1 && l2) || (h1 && h2)) begin
      state_c = BR_SLOW;
    end
  end

endmodule

// File: rtl/hbridge_coil_model.sv
// One stepper coil behind a full H-bridge: integrates saturated current, latches shoot-through.
module hbridge_coil_model
  import hbridge_pkg::*;
#(
  parameter int unsigned IMAX       = IMAX_DEFAULT,
  parameter int unsigned DRIVE_STEP = 4,
  parameter int unsigned SLOW_STEP  = 1,
  parameter int unsigned FAST_STEP  = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  hbridge_coil_model_if.slave  bus
);

  localparam logic signed [ARITH_W-1:0] IMAX_S  = ARITH_W'(IMAX);
  localparam logic signed [ARITH_W-1:0] DRIVE_S = ARITH_W'(DRIVE_STEP);
  localparam logic signed [ARITH_W-1:0] SLOW_S  = ARITH_W'(SLOW_STEP);
  localparam logic signed [ARITH_W-1:0] FAST_S  = ARITH_W'(FAST_STEP);

  bridge_state_e             decoded_c;
  bridge_state_e             bridge_state_d;
  bridge_state_e             bridge_state_q;
  logic signed [CUR_W-1:0]   current_d;
  logic signed [CUR_W-1:0]   current_q;
  logic                      fault_d;
  logic                      fault_q;
  logic signed [ARITH_W-1:0] cur_ext;
  logic signed [ARITH_W-1:0] next_ext;

  hbridge_decode u_decode (
    .high_1          (bus.high_1),
    .low_1           (bus.low_1),
    .high_2          (bus.high_2),
    .low_2           (bus.low_2),
    .polarity_invert (bus.polarity_invert_config),
    .state_c         (decoded_c)
  );

  // Next current, fault and state from the decoded bridge state; widened to avoid wrap.
  always_comb begin
    cur_ext        = {current_q[CUR_W-1], current_q};
    next_ext       = cur_ext;
    fault_d        = fault_q;
    bridge_state_d = decoded_c;
    case (decoded_c)
      BR_FWD: begin
        next_ext = cur_ext + DRIVE_S;
        if (next_ext > IMAX_S) next_ext = IMAX_S;
      end
      BR_REV: begin
        next_ext = cur_ext - DRIVE_S;
        if (next_ext < -IMAX_S) next_ext = -IMAX_S;
      end
      BR_SLOW:  next_ext = decay_toward_zero(cur_ext, SLOW_S);
      BR_SHOOT: begin
        next_ext = '0;
        fault_d  = 1'b1;
      end
      default:  next_ext = decay_toward_zero(cur_ext, FAST_S);
    endcase
    current_d = CUR_W'(next_ext);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      current_q      <= '0;
      fault_q        <= 1'b0;
      bridge_state_q <= BR_OFF;
    end else begin
      current_q      <= current_d;
      fault_q        <= fault_d;
      bridge_state_q <= bridge_state_d;
    end
  end

  assign bus.current      = current_q;
  assign bus.fault        = fault_q;
  assign bus.bridge_state = bridge_state_q;

endmodule

// File: tb/tb_hbridge_coil_model.sv
// Directed bench for the H-bridge coil model with hand-computed expectations.
module tb_hbridge_coil_model;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  hbridge_coil_model_if bus ();

  hbridge_coil_model dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_gates(input logic h1, input logic l1, input logic h2, input logic l2);
    bus.high_1 = h1;
    bus.low_1  = l1;
    bus.high_2 = h2;
    bus.low_2  = l2;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
  endtask

  function automatic int cur();
    return int'($signed(bus.current));
  endfunction

  initial begin
    bus.polarity_invert_config = 1'b0;
    set_gates(1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    tick(2);
    check_val("reset_current", cur(), 0);
    check_val("reset_fault", int'(bus.fault), 0);
    check_val("reset_state", int'(bus.bridge_state), 0);

    // Forward drive 100 cycles
    resetn = 1'b1;
    set_gates(1'b1, 1'b0, 1'b0, 1'b1);
    tick(100);
    check_val("fwd100_current", cur(), 400);
    check_val("fwd100_state", int'(bus.bridge_state), 1);
    check_val("fwd100_fault", int'(bus.fault), 0);

    // Saturation at +IMAX
    do_reset();
    check_val("sat_start", cur(), 0);
    tick(1023);
    check_val("sat_1023", cur(), 4092);
    tick(1);
    check_val("sat_1024", cur(), 4095);
    tick(76);
    check_val("sat_1100", cur(), 4095);
    set_gates(1'b0, 1'b1, 1'b1, 1'b0);
    tick(10);
    check_val("rev10_current", cur(), 4055);
    check_val("rev10_state", int'(bus.bridge_state), 2);

    // Slow decay with both lows
    do_reset();
    set_gates(1'b1, 1'b0, 1'b0, 1'b1);
    tick(100);
    set_gates(1'b0, 1'b1, 1'b0, 1'b1);
    tick(50);
    check_val("slow50_current", cur(), 350);
    check_val("slow50_state", int'(bus.bridge_state), 3);

    // Fast decay from -400 to 0, no overshoot
    do_reset();
    set_gates(1'b0, 1'b1, 1'b1, 1'b0);
    tick(100);
    check_val("rev100_current", cur(), -400);
    set_gates(1'b0, 1'b0, 1'b0, 1'b0);
    tick(50);
    check_val("off50_current", cur(), 0);
    check_val("off50_state", int'(bus.bridge_state), 0);
    tick(10);
    check_val("off60_current", cur(), 0);

    // Clamp at zero from -4 with fast decay; slow decay via both highs
    set_gates(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    check_val("rev1_current", cur(), -4);
    set_gates(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_val("highs_slow_current", cur(), -3);
    check_val("highs_slow_state", int'(bus.bridge_state), 3);
    set_gates(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    check_val("single_sw_clamp", cur(), 0);
    check_val("single_sw_state", int'(bus.bridge_state), 0);

    // Shoot-through and sticky fault
    do_reset();
    set_gates(1'b1, 1'b0, 1'b0, 1'b1);
    tick(100);
    set_gates(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_val("shoot_current", cur(), 0);
    check_val("shoot_fault", int'(bus.fault), 1);
    check_val("shoot_state", int'(bus.bridge_state), 4);
    set_gates(1'b1, 1'b0, 1'b0, 1'b1);
    tick(10);
    check_val("post_shoot_current", cur(), 40);
    check_val("post_shoot_fault", int'(bus.fault), 1);
    resetn = 1'b0;
    tick(1);
    check_val("fault_clear", int'(bus.fault), 0);
    check_val("fault_clear_current", cur(), 0);
    check_val("fault_clear_state", int'(bus.bridge_state), 0);

    // Polarity inversion
    resetn = 1'b1;
    bus.polarity_invert_config = 1'b1;
    tick(10);
    check_val("inv_current", cur(), -40);
    check_val("inv_state", int'(bus.bridge_state), 2);
    set_gates(1'b0, 1'b1, 1'b1, 1'b0);
    tick(5);
    check_val("inv_fwd_current", cur(), -20);
    check_val("inv_fwd_state", int'(bus.bridge_state), 1);
    set_gates(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    check_val("inv_shoot_fault", int'(bus.fault), 1);

    // Reset mid-ramp
    bus.polarity_invert_config = 1'b0;
    do_reset();
    set_gates(1'b1, 1'b0, 1'b0, 1'b1);
    tick(50);
    check_val("ramp_current", cur(), 200);
    resetn = 1'b0;
    tick(1);
    check_val("midreset_current", cur(), 0);
    check_val("midreset_fault", int'(bus.fault), 0);
    resetn = 1'b1;
    tick(1);
    check_val("resume_current", cur(), 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
